gpio_checkpoint_monitor: RTL

//  Synthesizable checkpoint-sequence monitor for GPIO status words driven by firmware.

---
 rtl/gpio_checkpoint_monitor_if.sv | 30 +++
 rtl/gpio_checkpoint_monitor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gpio_checkpoint_monitor_if.sv
// Bus bundle for the GPIO checkpoint monitor: firmware-facing stimulus in,
// registered progress/result flags out.
interface gpio_checkpoint_monitor_if #(
  parameter int unsigned CHECK_W    = 16,
  parameter int unsigned NUM_STAGES = 4
);
  localparam int unsigned SW = $clog2(NUM_STAGES + 1);

  logic                          enable;
  logic [CHECK_W-1:0]            checkbits;
  logic [NUM_STAGES*CHECK_W-1:0] expect_flat;
  logic                          abort_en;
  logic [CHECK_W-1:0]            abort_value;
  logic [SW-1:0]                 stage_idx;
  logic                          started;
  logic                          passed;
  logic                          failed;
  logic                          timed_out;
  logic                          done;

  modport master (
    output enable, checkbits, expect_flat, abort_en, abort_value,
    input  stage_idx, started, passed, failed, timed_out, done
  );

  modport slave (
    input  enable, checkbits, expect_flat, abort_en, abort_value,
    output stage_idx, started, passed, failed, timed_out, done
  );
endinterface

// File: rtl/gpio_checkpoint_monitor.sv
// Watches a glitch-filtered checkpoint bus for an ordered list of expected values and
// reports pass, fail (abort value) or timeout.
module gpio_checkpoint_monitor #(
  parameter int unsigned CHECK_W        = 16,
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMEOUT_MODE   = 0
) (
  input  logic                      clock,
  input  logic                      resetb,
  gpio_checkpoint_monitor_if.slave  io_mon
);
  localparam int unsigned SW = $clog2(NUM_STAGES + 1);
  localparam int unsigned RW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StArmed, StRun, StPass, StFail, StTmo} state_e;

  state_e             r_state;
  logic [CHECK_W-1:0] r_s;
  logic [RW-1:0]      r_run_cnt;
  logic [TW-1:0]      r_tmo_cnt;
  logic [SW-1:0]      r_stage_idx;
  logic               r_started;
  logic               r_passed;
  logic               r_failed;
  logic               r_timed_out;
  logic               r_done;

  logic               w_changed;
  logic [RW-1:0]      w_run_next;
  logic               w_qual;
  logic [CHECK_W-1:0] w_exp;
  logic               w_match;
  logic               w_abort;
  logic               w_tmo_last;
  logic               w_last_stage;

  assign w_changed  = (io_mon.checkbits != r_s);
  assign w_run_next = w_changed                          ? RW'(1)      :
                      (r_run_cnt == RW'(STABLE_CYCLES))  ? r_run_cnt   :
                                                           r_run_cnt + RW'(1);
  // One pulse per stable run: only on the edge the count first reaches the threshold.
  assign w_qual = (w_run_next == RW'(STABLE_CYCLES)) &&
                  (w_changed || (r_run_cnt != RW'(STABLE_CYCLES)));

  always_comb begin
    w_exp = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (r_stage_idx == SW'(k)) w_exp = io_mon.expect_flat[k*CHECK_W +: CHECK_W];
    end
  end

  assign w_match      = w_qual && (io_mon.checkbits == w_exp);
  assign w_abort      = w_qual && io_mon.abort_en && (io_mon.checkbits == io_mon.abort_value);
  assign w_tmo_last   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_last_stage = (r_stage_idx == SW'(NUM_STAGES - 1));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state     <= StIdle;
      r_s         <= '0;
      r_run_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_stage_idx <= '0;
      r_started   <= 1'b0;
      r_passed    <= 1'b0;
      r_failed    <= 1'b0;
      r_timed_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_s       <= io_mon.checkbits;
      r_run_cnt <= w_run_next;
      if (!io_mon.enable) begin
        r_state     <= StIdle;
        r_tmo_cnt   <= '0;
        r_stage_idx <= '0;
        r_started   <= 1'b0;
        r_passed    <= 1'b0;
        r_failed    <= 1'b0;
        r_timed_out <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_state   <= StArmed;
            r_tmo_cnt <= '0;
          end
          StArmed, StRun: begin
            if (w_match) begin
              r_stage_idx <= r_stage_idx + SW'(1);
              r_started   <= 1'b1;
              // Global budget saturates at its last count so the next idle edge expires it.
              if (TIMEOUT_MODE != 0)  r_tmo_cnt <= '0;
              else if (!w_tmo_last)   r_tmo_cnt <= r_tmo_cnt + TW'(1);
              if (w_last_stage) begin
                r_state  <= StPass;
                r_passed <= 1'b1;
                r_done   <= 1'b1;
              end else begin
                r_state <= StRun;
              end
            end else if (w_abort) begin
              r_state  <= StFail;
              r_failed <= 1'b1;
              r_done   <= 1'b1;
            end else if (w_tmo_last) begin
              r_state     <= StTmo;
              r_timed_out <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_mon.stage_idx = r_stage_idx;
  assign io_mon.started   = r_started;
  assign io_mon.passed    = r_passed;
  assign io_mon.failed    = r_failed;
  assign io_mon.timed_out = r_timed_out;
  assign io_mon.done      = r_done;
endmodule
